// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 serial receiver (LSB first) for the clk_uart domain.
//
// Recovers frames from the asynchronous rxd pin, checks the start and stop
// bits, and holds each good byte in a one-entry buffer for the bus side.
//
// Ports
//   clk_uart     in   only clock
//   rst_n        in   asynchronous, active-low reset
//   rxd          in   serial line, idle high, asynchronous to clk_uart
//   data         out  [7:0] last accepted byte, valid while data_ready is 1
//   data_ready   out  level, 1 while an unread byte is held
//   rd_ack       in   single-cycle consume strobe
//   frame_err    out  one-cycle pulse when the stop bit samples 0
//   overrun      out  one-cycle pulse when a good frame is dropped (buffer full)
//   o_dbg_state  out  [2:0] current receiver state (debug observation only)
//
// Handshake: data_ready is a level that rises when a byte is stored and stays
// high until the consumer pulses rd_ack for one cycle. A delivery that meets
// a full buffer is accepted only if rd_ack is high in that same cycle (the old
// byte is consumed and replaced); otherwise the new byte is dropped, the old
// byte is kept and overrun pulses. rd_ack while data_ready is 0 does nothing.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int BAUD           = 115200,
  parameter int UART_CLK       = 11059200,
  parameter int COUNTER_PERIOD = UART_CLK / BAUD - 1,
  parameter int HALF_PERIOD    = COUNTER_PERIOD / 2
) (
  input  logic       clk_uart,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_ready,
  input  logic       rd_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] o_dbg_state
);

  localparam logic [14:0] P_FULL = 15'(COUNTER_PERIOD);
  localparam logic [14:0] P_HALF = 15'(HALF_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Synchroniser flops reset high so a reset never looks like a start bit.
  logic        r_rxd_s1;
  logic        r_rxd_s2;

  state_t      r_state;
  state_t      w_next_state;

  logic [14:0] r_baud_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_data_ready;
  logic        r_frame_err;
  logic        r_overrun;

  logic        w_fire;
  logic        w_load_half;
  logic        w_load_full;
  logic        w_clr_bit;
  logic        w_inc_bit;
  logic        w_shift_en;
  logic        w_deliver;
  logic        w_ferr;
  logic        w_accept;

  assign w_fire = (r_baud_cnt == 15'd0);

  // A good frame is stored if the buffer is empty or is being consumed now.
  assign w_accept = w_deliver && (!r_data_ready || rd_ack);

  // -------------------------------------------------------------------------
  // Input synchroniser
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
    end else begin
      r_rxd_s1 <= rxd;
      r_rxd_s2 <= r_rxd_s1;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_load_half  = 1'b0;
    w_load_full  = 1'b0;
    w_clr_bit    = 1'b0;
    w_inc_bit    = 1'b0;
    w_shift_en   = 1'b0;
    w_deliver    = 1'b0;
    w_ferr       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!r_rxd_s2) begin
          w_load_half  = 1'b1;
          w_next_state = S_START;
        end
      end

      S_START: begin
        if (w_fire) begin
          if (!r_rxd_s2) begin
            w_load_full  = 1'b1;
            w_clr_bit    = 1'b1;
            w_next_state = S_DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            w_next_state = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (w_fire) begin
          w_shift_en  = 1'b1;
          w_load_full = 1'b1;
          if (r_bit_cnt == 3'd7) begin
            w_next_state = S_STOP;
          end else begin
            w_inc_bit = 1'b1;
          end
        end
      end

      S_STOP: begin
        if (w_fire) begin
          if (r_rxd_s2) begin
            // Back to IDLE at mid stop bit so the next start edge is caught.
            w_deliver    = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_ferr       = 1'b1;
            w_next_state = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        // A held-low line (break) must not be seen as a stream of starts.
        if (r_rxd_s2) begin
          w_next_state = S_IDLE;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Bit timer, bit counter and shift register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= 15'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      if (w_load_half) begin
        r_baud_cnt <= P_HALF;
      end else if (w_load_full) begin
        r_baud_cnt <= P_FULL;
      end else if (!w_fire) begin
        r_baud_cnt <= r_baud_cnt - 15'd1;
      end

      if (w_clr_bit) begin
        r_bit_cnt <= 3'd0;
      end else if (w_inc_bit) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      // LSB arrives first, so shift in from the top.
      if (w_shift_en) begin
        r_shift <= {r_rxd_s2, r_shift[7:1]};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Receive buffer and status pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= 8'h00;
      r_data_ready <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_deliver && !w_accept;

      if (w_accept) begin
        r_data       <= r_shift;
        r_data_ready <= 1'b1;
      end else if (rd_ack && !w_deliver) begin
        r_data_ready <= 1'b0;
      end
    end
  end

  assign data        = r_data;
  assign data_ready  = r_data_ready;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : self-checking bench for uart_rx.
//
// Frames are driven at exactly 96 clocks per bit. Every frame the driver
// starts is logged with the cycle at which its stop bit is judged, and an
// event-level model applies the buffer/ack/overrun rules at that cycle to
// predict data, data_ready, frame_err and overrun every cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int P   = 95;
  localparam int H   = 47;
  localparam int BIT = P + 1;
  // Pin driven low just after edge n: two synchroniser edges, IDLE sees it at
  // n+3, start centre H+1 later, stop centre nine bit times after that.
  localparam int LAT = 3 + H + 1 + 9 * BIT;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic       clk_uart = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rxd      = 1'b1;
  logic       rd_ack   = 1'b0;
  logic [7:0] data;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic [2:0] dbg_state;

  always #5 clk_uart = ~clk_uart;

  uart_rx #(
    .BAUD     (115200),
    .UART_CLK (11059200)
  ) dut (
    .clk_uart    (clk_uart),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .data        (data),
    .data_ready  (data_ready),
    .rd_ack      (rd_ack),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .o_dbg_state (dbg_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    bit         good;
    logic [7:0] b;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  logic [7:0] m_data = 8'h00;
  logic       m_rdy  = 1'b0;
  logic       m_fe   = 1'b0;
  logic       m_ov   = 1'b0;

  int ack_mode = 0;
  int ack_at   = -10;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int rise_cyc = -1;

  logic       prev_rdy  = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_deliveries(string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: at each judged stop bit apply the delivery rule.
  // -------------------------------------------------------------------------
  always @(posedge clk_uart) begin : model_blk
    ev_t e;
    bit  took;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_data = 8'h00;
      m_rdy  = 1'b0;
      m_fe   = 1'b0;
      m_ov   = 1'b0;
      ev_q.delete();
    end else begin
      took = 1'b0;
      m_fe = 1'b0;
      m_ov = 1'b0;
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        e = ev_q.pop_front();
        if (!e.good) begin
          m_fe = 1'b1;
        end else if (!m_rdy || rd_ack) begin
          m_data = e.b;
          m_rdy  = 1'b1;
          took   = 1'b1;
        end else begin
          m_ov = 1'b1;
        end
      end
      if (!took && rd_ack) m_rdy = 1'b0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk_uart) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ({data, data_ready, frame_err, overrun} !== {m_data, m_rdy, m_fe, m_ov}) begin
        errors++;
        if (errors < 20)
          $display("FAIL cycle_%0d: got data=%h rdy=%b fe=%b ov=%b expected data=%h rdy=%b fe=%b ov=%b",
                   cyc, data, data_ready, frame_err, overrun, m_data, m_rdy, m_fe, m_ov);
      end
    end
  end

  // Observation of deliveries and pulses for the directed literal checks.
  always @(negedge clk_uart) begin
    if (rst_n === 1'b1) begin
      if (data_ready && (!prev_rdy || data !== prev_data)) begin
        got_q.push_back(data);
        if (rise_cyc < 0) rise_cyc = cyc;
      end
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      prev_rdy  = data_ready;
      prev_data = data;
    end else begin
      prev_rdy  = 1'b0;
      prev_data = 8'h00;
    end
  end

  // -------------------------------------------------------------------------
  // rd_ack driver: 0 none, 1 random single-cycle acks, 2 ack on cycle ack_at
  // -------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk_uart);
      #1;
      case (ack_mode)
        1:       rd_ack = !rd_ack && data_ready && ($urandom_range(0, 3) == 0);
        2:       rd_ack = (cyc == ack_at - 1);
        default: rd_ack = 1'b0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk_uart);
      #1;
    end
  endtask

  task automatic idle(int n);
    rxd = 1'b1;
    tick(n);
  endtask

  task automatic drive_bits(logic [9:0] f, int nbits);
    for (int i = 0; i < nbits; i++) begin
      rxd = f[i];
      tick(BIT);
    end
  endtask

  task automatic send_frame(logic [7:0] b, logic stop);
    ev_t e;
    e.cyc  = cyc + LAT;
    e.good = stop;
    e.b    = b;
    ev_q.push_back(e);
    drive_bits({stop, b, 1'b0}, 10);
  endtask

  task automatic drain();
    ack_mode = 1;
    tick(60);
    ack_mode = 0;
    tick(2);
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  int         start_cyc;
  logic [7:0] rb;
  logic       rs;

  initial begin
    tick(5);
    check("reset_data",  data, 8'h00);
    check("reset_ready", data_ready, 1'b0);
    check("reset_ferr",  frame_err, 1'b0);
    check("reset_ovr",   overrun, 1'b0);
    check("reset_state", dbg_state, 3'd0);
    rst_n = 1'b1;
    idle(10);

    // Single byte
    clear_obs();
    rise_cyc  = -1;
    start_cyc = cyc;
    send_frame(8'h55, 1'b1);
    idle(50);
    check("single_data",  data, 8'h55);
    check("single_ready", data_ready, 1'b1);
    check("single_lat_ok", (rise_cyc - start_cyc >= 910) && (rise_cyc - start_cyc <= 916), 1'b1);
    check("single_ferr_cnt", fe_cnt, 0);
    check("single_ovr_cnt",  ov_cnt, 0);

    // Back-to-back frames
    drain();
    clear_obs();
    ack_mode = 1;
    exp_q = '{8'hA5, 8'h3C};
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(200);
    check_deliveries("b2b");
    check("b2b_ferr_cnt", fe_cnt, 0);
    check("b2b_ovr_cnt",  ov_cnt, 0);

    // Glitch rejection
    drain();
    clear_obs();
    ack_mode = 1;
    rxd = 1'b0;
    tick(20);
    idle(100);
    check("glitch_state", dbg_state, 3'd0);
    check("glitch_rx_count", got_q.size(), 0);
    check("glitch_ferr_cnt", fe_cnt, 0);
    check("glitch_ovr_cnt",  ov_cnt, 0);
    exp_q = '{8'h81};
    send_frame(8'h81, 1'b1);
    idle(200);
    check_deliveries("glitch_after");

    // Framing error and break
    drain();
    clear_obs();
    send_frame(8'h0F, 1'b0);
    rxd = 1'b0;
    tick(2000);
    idle(20);
    check("break_ferr_cnt", fe_cnt, 1);
    check("break_rx_count", got_q.size(), 0);
    check("break_ready", data_ready, 1'b0);
    ack_mode = 1;
    exp_q = '{8'h7E};
    send_frame(8'h7E, 1'b1);
    idle(200);
    check_deliveries("break_after");

    // Overrun, then acknowledge on the stop-fire cycle
    drain();
    clear_obs();
    check("ovr_pre_ready", data_ready, 1'b0);
    send_frame(8'h11, 1'b1);
    idle(20);
    send_frame(8'h22, 1'b1);
    idle(20);
    check("ovr_cnt",   ov_cnt, 1);
    check("ovr_data",  data, 8'h11);
    check("ovr_ready", data_ready, 1'b1);
    ack_at   = cyc + LAT;
    ack_mode = 2;
    send_frame(8'h22, 1'b1);
    idle(20);
    ack_mode = 0;
    check("ack_same_ovr_cnt", ov_cnt, 1);
    check("ack_same_data",    data, 8'h22);
    check("ack_same_ready",   data_ready, 1'b1);

    // Reset during bit 4 of 0xC3 (buffer still holds 0x22)
    clear_obs();
    drive_bits({1'b1, 8'hC3, 1'b0}, 5);
    rxd = 1'b0;
    tick(48);
    rst_n = 1'b0;
    rxd   = 1'b1;
    #1;
    check("rst_mid_data",  data, 8'h00);
    check("rst_mid_ready", data_ready, 1'b0);
    check("rst_mid_ferr",  frame_err, 1'b0);
    check("rst_mid_ovr",   overrun, 1'b0);
    check("rst_mid_state", dbg_state, 3'd0);
    tick(4);
    rst_n = 1'b1;
    idle(5);
    clear_obs();
    ack_mode = 1;
    exp_q = '{8'h5A};
    send_frame(8'h5A, 1'b1);
    idle(200);
    check_deliveries("rst_after");
    check("rst_after_ferr_cnt", fe_cnt, 0);
    check("rst_after_ovr_cnt",  ov_cnt, 0);

    // Randomised frames, gaps, stop bits and acknowledge timing
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 5) != 0);
      send_frame(rb, rs);
      if (!rs) idle(int'($urandom_range(10, 200)));
      else     idle(int'($urandom_range(0, 150)));
    end
    idle(300);
    check("events_drained", ev_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
